// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/MEM unified-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  function automatic int unsigned lat_cnt_w(input int unsigned latency);
    return $clog2(latency + 1);
  endfunction

endpackage

// File: rtl/arb_priority_sel.sv
// Data-first grant selection with a starvation counter that forces an
// instruction grant after STARVE_LIMIT consecutive data grants.
module arb_priority_sel
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   i_req,
  input  logic   d_req,
  input  logic   i_idle,
  output logic   o_grant,
  output owner_e o_owner
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] r_starve;
  logic          w_d_win;

  always_comb begin
    w_d_win = d_req && (!i_req || (r_starve < SW'(STARVE_LIMIT)));
    o_grant = i_idle && (d_req || i_req);
    o_owner = w_d_win ? OWN_D : OWN_I;
  end

  // Counts only data grants that bypassed a waiting fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_starve <= '0;
    end else if (o_grant) begin
      if (o_owner == OWN_D && i_req) r_starve <= r_starve + SW'(1);
      else                           r_starve <= '0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-port memory between instruction fetch
// and data access; data side has priority, bounded by a starvation limit.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned LATENCY      = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              pipe_stall
);

  localparam int unsigned CNT_W = lat_cnt_w(LATENCY);

  state_e            r_state, w_state_nxt;
  owner_e            r_owner, w_owner, w_resp_owner;
  logic              r_we;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_i_ack, r_d_ack, r_err, r_mem_en, r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata, r_i_rdata, r_d_rdata;

  logic              w_grant, w_misal, w_last, w_issue, w_to_resp, w_resp_we;
  logic              w_i_ack_nxt, w_d_ack_nxt, w_err_nxt, w_rd_load;
  logic [ADDR_W-1:0] w_gaddr;
  logic [DATA_W-1:0] w_rd_val;

  arb_priority_sel #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_sel (
    .clk    (clk),
    .reset  (reset),
    .i_req  (i_req),
    .d_req  (d_req),
    .i_idle (r_state == IDLE),
    .o_grant(w_grant),
    .o_owner(w_owner)
  );

  assign w_gaddr = (w_owner == OWN_D) ? d_addr : i_addr;
  assign w_misal = |w_gaddr[1:0];
  assign w_last  = (r_cnt == CNT_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_grant) w_state_nxt = w_misal ? RESP : ISSUE;
      ISSUE:   w_state_nxt = WAIT;
      WAIT:    if (w_last) w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // RESP is entered either straight from IDLE (rejected) or from WAIT, so the
  // response owner/direction come from the live grant or the latched copy.
  always_comb begin
    w_issue      = (r_state == IDLE) && w_grant && !w_misal;
    w_to_resp    = (w_state_nxt == RESP) && (r_state != RESP);
    w_resp_owner = (r_state == IDLE) ? w_owner : r_owner;
    w_resp_we    = (r_state == IDLE) ? ((w_owner == OWN_D) && d_we) : r_we;
    w_i_ack_nxt  = w_to_resp && (w_resp_owner == OWN_I);
    w_d_ack_nxt  = w_to_resp && (w_resp_owner == OWN_D);
    w_err_nxt    = w_to_resp && (r_state == IDLE);
    w_rd_load    = w_to_resp && !w_resp_we;
    w_rd_val     = (r_state == IDLE) ? '0 : mem_rdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner     <= OWN_I;
      r_we        <= 1'b0;
      r_cnt       <= '0;
      r_i_ack     <= 1'b0;
      r_d_ack     <= 1'b0;
      r_err       <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
    end else begin
      r_i_ack  <= w_i_ack_nxt;
      r_d_ack  <= w_d_ack_nxt;
      r_err    <= w_err_nxt;
      r_mem_en <= w_issue;
      r_mem_we <= w_issue && (w_owner == OWN_D) && d_we;
      if ((r_state == IDLE) && w_grant) begin
        r_owner <= w_owner;
        r_we    <= (w_owner == OWN_D) && d_we;
      end
      if (w_issue) begin
        r_mem_addr  <= w_gaddr;
        r_mem_wdata <= (w_owner == OWN_D) ? d_wdata : '0;
      end
      if (r_state == ISSUE)     r_cnt <= CNT_W'(LATENCY);
      else if (r_state == WAIT) r_cnt <= r_cnt - CNT_W'(1);
      if (w_rd_load && (w_resp_owner == OWN_I)) r_i_rdata <= w_rd_val;
      if (w_rd_load && (w_resp_owner == OWN_D)) r_d_rdata <= w_rd_val;
    end
  end

  assign i_ack      = r_i_ack;
  assign d_ack      = r_d_ack;
  assign err        = r_err;
  assign i_rdata    = r_i_rdata;
  assign d_rdata    = r_d_rdata;
  assign mem_en     = r_mem_en;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign pipe_stall = (i_req && !i_ack) || (d_req && !d_ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: LATENCY=1 instance (a_*) and LATENCY=3 instance (b_*).
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // instance A, LATENCY = 1
  logic        a_i_req = 0, a_d_req = 0, a_d_we = 0;
  logic [31:0] a_i_addr = 0, a_d_addr = 0, a_d_wdata = 0;
  logic        a_i_ack, a_d_ack, a_err, a_mem_en, a_mem_we, a_stall;
  logic [31:0] a_i_rdata, a_d_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;

  // instance B, LATENCY = 3
  logic        b_i_req = 0, b_d_req = 0, b_d_we = 0;
  logic [31:0] b_i_addr = 0, b_d_addr = 0, b_d_wdata = 0;
  logic        b_i_ack, b_d_ack, b_err, b_mem_en, b_mem_we, b_stall;
  logic [31:0] b_i_rdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(1), .STARVE_LIMIT(4)) dut_a (
    .clk(clk), .reset(rst),
    .i_req(a_i_req), .i_addr(a_i_addr), .i_ack(a_i_ack), .i_rdata(a_i_rdata),
    .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
    .d_ack(a_d_ack), .d_rdata(a_d_rdata), .err(a_err),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .pipe_stall(a_stall)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(3), .STARVE_LIMIT(4)) dut_b (
    .clk(clk), .reset(rst),
    .i_req(b_i_req), .i_addr(b_i_addr), .i_ack(b_i_ack), .i_rdata(b_i_rdata),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_ack(b_d_ack), .d_rdata(b_d_rdata), .err(b_err),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .pipe_stall(b_stall)
  );

  // Memory models: read data is driven only in its valid cycle, garbage otherwise.
  logic [31:0] mem_a [0:63];
  logic [31:0] mem_b [0:63];
  logic        va;
  logic [5:0]  aa;
  logic [2:0]  vb;
  logic [5:0]  ab [0:2];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) begin
        mem_a[i] <= 32'h0;
        mem_b[i] <= 32'h0;
      end
      mem_a[1]  <= 32'h8C220000;
      mem_a[2]  <= 32'h11112222;
      mem_a[4]  <= 32'h44440010;
      mem_b[16] <= 32'hCAFEF00D;
      va <= 1'b0;
      aa <= '0;
      vb <= '0;
      for (int i = 0; i < 3; i++) ab[i] <= '0;
    end else begin
      va <= a_mem_en & ~a_mem_we;
      aa <= a_mem_addr[7:2];
      if (a_mem_en & a_mem_we) mem_a[a_mem_addr[7:2]] <= a_mem_wdata;
      vb <= {vb[1:0], b_mem_en & ~b_mem_we};
      ab[0] <= b_mem_addr[7:2];
      ab[1] <= ab[0];
      ab[2] <= ab[1];
      if (b_mem_en & b_mem_we) mem_b[b_mem_addr[7:2]] <= b_mem_wdata;
    end
  end

  assign a_mem_rdata = va    ? mem_a[aa]    : 32'hBAD0BAD0;
  assign b_mem_rdata = vb[2] ? mem_b[ab[2]] : 32'hBAD0BAD0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic        en, we, iack, dack, stall;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [31:0] wd;
  } vec_t;

  function automatic vec_t row(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                               input logic [31:0] da, input logic [31:0] dd,
                               input logic en, input logic we, input logic ik, input logic dk,
                               input logic st, input logic [31:0] ad, input logic [31:0] rd,
                               input logic [31:0] wd);
    vec_t v;
    v.ireq = ir; v.iaddr = ia; v.dreq = dr; v.dwe = dw; v.daddr = da; v.dwdata = dd;
    v.en = en; v.we = we; v.iack = ik; v.dack = dk; v.stall = st;
    v.addr = ad; v.rdata = rd; v.wd = wd;
    return v;
  endfunction

  vec_t vt [0:13];

  initial begin
    int    nacks;
    int    seen [0:5];
    int    exp_seq [0:5];
    bit    drop_i;
    string nm;

    // single fetch (rows 0-4), then I/D collision (rows 5-13)
    vt[0]  = row(1, 32'h4, 0, 0, 0, 0,                    0, 0, 0, 0, 1, 0,     0,            0);
    vt[1]  = row(1, 32'h4, 0, 0, 0, 0,                    1, 0, 0, 0, 1, 32'h4, 0,            0);
    vt[2]  = row(1, 32'h4, 0, 0, 0, 0,                    0, 0, 0, 0, 1, 0,     0,            0);
    vt[3]  = row(1, 32'h4, 0, 0, 0, 0,                    0, 0, 1, 0, 0, 0,     32'h8C220000, 0);
    vt[4]  = row(0, 0,     0, 0, 0, 0,                    0, 0, 0, 0, 0, 0,     0,            0);
    vt[5]  = row(1, 32'h8, 1, 1, 32'h20, 32'hDEADBEEF,    0, 0, 0, 0, 1, 0,     0,            0);
    vt[6]  = row(1, 32'h8, 1, 1, 32'h20, 32'hDEADBEEF,    1, 1, 0, 0, 1, 32'h20, 0, 32'hDEADBEEF);
    vt[7]  = row(1, 32'h8, 1, 1, 32'h20, 32'hDEADBEEF,    0, 0, 0, 0, 1, 0,     0,            0);
    vt[8]  = row(1, 32'h8, 1, 1, 32'h20, 32'hDEADBEEF,    0, 0, 0, 1, 1, 0,     0,            0);
    vt[9]  = row(1, 32'h8, 0, 0, 0, 0,                    0, 0, 0, 0, 1, 0,     0,            0);
    vt[10] = row(1, 32'h8, 0, 0, 0, 0,                    1, 0, 0, 0, 1, 32'h8, 0,            0);
    vt[11] = row(1, 32'h8, 0, 0, 0, 0,                    0, 0, 0, 0, 1, 0,     0,            0);
    vt[12] = row(1, 32'h8, 0, 0, 0, 0,                    0, 0, 1, 0, 0, 0,     32'h11112222, 0);
    vt[13] = row(0, 0,     0, 0, 0, 0,                    0, 0, 0, 0, 0, 0,     0,            0);
    exp_seq = '{1, 1, 1, 1, 0, 1};

    // reset state
    @(negedge clk);
    chk("rst_a_mem_en", {31'b0, a_mem_en}, 0);
    chk("rst_a_acks", {29'b0, a_i_ack, a_d_ack, a_err}, 0);
    chk("rst_a_mem_addr", a_mem_addr, 0);
    chk("rst_a_rdata", a_i_rdata | a_d_rdata, 0);
    chk("rst_b_outs", {27'b0, b_mem_en, b_mem_we, b_i_ack, b_d_ack, b_err}, 0);
    @(posedge clk); #1 rst = 0;
    @(posedge clk);

    // table-driven vectors on instance A
    for (int k = 0; k < 14; k++) begin
      @(posedge clk); #1;
      a_i_req = vt[k].ireq; a_i_addr = vt[k].iaddr;
      a_d_req = vt[k].dreq; a_d_we = vt[k].dwe; a_d_addr = vt[k].daddr; a_d_wdata = vt[k].dwdata;
      @(negedge clk);
      nm = $sformatf("row%0d", k);
      chk({nm, "_mem_en"}, {31'b0, a_mem_en}, {31'b0, vt[k].en});
      chk({nm, "_mem_we"}, {31'b0, a_mem_we}, {31'b0, vt[k].we});
      chk({nm, "_i_ack"}, {31'b0, a_i_ack}, {31'b0, vt[k].iack});
      chk({nm, "_d_ack"}, {31'b0, a_d_ack}, {31'b0, vt[k].dack});
      chk({nm, "_err"}, {31'b0, a_err}, 0);
      chk({nm, "_stall"}, {31'b0, a_stall}, {31'b0, vt[k].stall});
      if (vt[k].en) chk({nm, "_mem_addr"}, a_mem_addr, vt[k].addr);
      if (vt[k].we) chk({nm, "_mem_wdata"}, a_mem_wdata, vt[k].wd);
      if (vt[k].iack) chk({nm, "_i_rdata"}, a_i_rdata, vt[k].rdata);
    end

    // starvation: D held with back-to-back re-presentation, I waiting
    @(posedge clk); #1;
    a_i_req = 1; a_i_addr = 32'h4;
    a_d_req = 1; a_d_we = 0; a_d_addr = 32'h20; a_d_wdata = 0;
    nacks = 0; drop_i = 0;
    for (int c = 0; c < 60 && nacks < 6; c++) begin
      @(negedge clk);
      if (a_d_ack && nacks < 6) begin
        if (nacks == 0) chk("starve_d_rdata", a_d_rdata, 32'hDEADBEEF);
        seen[nacks] = 1; nacks++;
      end
      if (a_i_ack && nacks < 6) begin
        chk("starve_i_rdata", a_i_rdata, 32'h8C220000);
        seen[nacks] = 0; nacks++; drop_i = 1;
      end
      @(posedge clk); #1;
      if (drop_i) a_i_req = 0;
    end
    a_d_req = 0; a_i_req = 0;
    chk("starve_ack_count", nacks, 6);
    for (int k = 0; k < 6; k++)
      if (k < nacks) chk($sformatf("starve_ack%0d_is_d", k), seen[k], exp_seq[k]);

    // misaligned data read
    @(posedge clk); #1;
    a_d_req = 1; a_d_we = 0; a_d_addr = 32'h22;
    @(negedge clk);
    chk("mis_R_mem_en", {31'b0, a_mem_en}, 0);
    chk("mis_R_d_ack", {31'b0, a_d_ack}, 0);
    @(negedge clk);
    chk("mis_R1_d_ack", {31'b0, a_d_ack}, 1);
    chk("mis_R1_err", {31'b0, a_err}, 1);
    chk("mis_R1_mem_en", {31'b0, a_mem_en}, 0);
    chk("mis_R1_d_rdata", a_d_rdata, 0);
    @(posedge clk); #1 a_d_req = 0;
    @(negedge clk);
    chk("mis_R2_err", {31'b0, a_err}, 0);
    chk("mis_R2_d_ack", {31'b0, a_d_ack}, 0);

    // LATENCY = 3 read on instance B
    @(posedge clk); #1;
    b_d_req = 1; b_d_we = 0; b_d_addr = 32'h40;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("lat3_R%0d_mem_en", k), {31'b0, b_mem_en}, {31'b0, k == 1});
      chk($sformatf("lat3_R%0d_d_ack", k), {31'b0, b_d_ack}, {31'b0, k == 5});
      if (k == 1) chk("lat3_mem_addr", b_mem_addr, 32'h40);
      if (k == 5) chk("lat3_d_rdata", b_d_rdata, 32'hCAFEF00D);
      @(posedge clk); #1;
      if (k == 5) b_d_req = 0;
    end

    // reset in the middle of WAIT on instance A
    a_d_req = 1; a_d_we = 0; a_d_addr = 32'h10;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1;
    #1;
    chk("rstw_mem_en", {31'b0, a_mem_en}, 0);
    chk("rstw_d_ack", {31'b0, a_d_ack}, 0);
    chk("rstw_mem_addr", a_mem_addr, 0);
    chk("rstw_i_rdata", a_i_rdata, 0);
    a_d_req = 0;
    @(posedge clk); #1 rst = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("rstw_c%0d_d_ack", k), {31'b0, a_d_ack}, 0);
      chk($sformatf("rstw_c%0d_mem_en", k), {31'b0, a_mem_en}, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
